// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- multi-port register file with hardware clear sequencer
//
// Purpose:
//   DEPTH = 2**ADDR_W registers of DATA_W bits. Register 0 is hardwired to
//   zero. Two write ports (port 1 wins on an address collision), NRD
//   combinational read ports. A two-state clear FSM (IDLE/CLEAR) walks a
//   pointer from 1 to DEPTH-1, zeroing one register per cycle. Reset forces
//   the FSM into CLEAR, so the array is initialised only by this sequence.
//   While the clear runs, user writes are dropped and all reads return 0.
//
// Ports:
//   clk      in   1            clock, rising edge
//   rst      in   1            asynchronous reset, active low
//   we0/we1  in   1            write enables
//   waddr0/1 in   ADDR_W       write addresses
//   wdata0/1 in   DATA_W       write data
//   re       in   NRD          per-port read enable (bit i -> port i)
//   raddr    in   NRD*ADDR_W   read addresses (port i at [i*ADDR_W +: ADDR_W])
//   rdata    out  NRD*DATA_W   read data      (port i at [i*DATA_W +: DATA_W])
//   clr_req  in   1            single-cycle request to zero all registers
//   clr_busy out  1            clear sequence in progress (registered)
//
// Configuration:
//   REGFILE_MP_BYPASS_EN -- when defined, an accepted write to the address a
//   read port is reading is forwarded to that port in the same cycle
//   (wdata1 takes priority over wdata0). When undefined, reads return the
//   stored value and new data appears from the cycle after the write.
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    input  logic                  clr_req,
    output logic                  clr_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_ADDR  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1'b1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    // Storage array: deliberately not reset; the clear sequence initialises it.
    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              r_clr_busy;

    logic              w_wacc0;
    logic              w_wacc1;
    logic [NRD*DATA_W-1:0] w_rdata;

    // A write is accepted only outside reset and clear, and never to address 0.
    assign w_wacc0 = we0 & rst & ~r_clr_busy & (waddr0 != ZERO_ADDR);
    assign w_wacc1 = we1 & rst & ~r_clr_busy & (waddr1 != ZERO_ADDR);

    // Clear FSM next-state and pointer logic.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = FIRST_ADDR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CLEAR: begin
                // clr_req is ignored here so a running sequence never restarts.
                // The pointer holds at DEPTH-1 instead of wrapping to 0.
                if (r_ptr == LAST_ADDR) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ptr_nxt   = r_ptr + FIRST_ADDR;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_ptr_nxt   = FIRST_ADDR;
            end
        endcase
    end

    // Clear FSM state, pointer and registered busy flag; reset enters CLEAR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_CLEAR;
            r_ptr      <= FIRST_ADDR;
            r_clr_busy <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_clr_busy <= (w_state_nxt == S_CLEAR);
        end
    end

    // Storage update: clear sweep has priority; port 1 is written last so it wins.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_ptr] <= {DATA_W{1'b0}};
        end else begin
            if (w_wacc0) begin
                r_mem[waddr0] <= wdata0;
            end
            if (w_wacc1) begin
                r_mem[waddr1] <= wdata1;
            end
        end
    end

    // Combinational read ports with zero gating and optional write forwarding.
    always_comb begin
        w_rdata = {(NRD*DATA_W){1'b0}};
        for (int i = 0; i < NRD; i++) begin
            logic [ADDR_W-1:0] ra;
            ra = raddr[i*ADDR_W +: ADDR_W];
            if (!re[i] || (ra == ZERO_ADDR) || r_clr_busy) begin
                w_rdata[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
`ifdef REGFILE_MP_BYPASS_EN
            end else if (w_wacc1 && (waddr1 == ra)) begin
                w_rdata[i*DATA_W +: DATA_W] = wdata1;
            end else if (w_wacc0 && (waddr0 == ra)) begin
                w_rdata[i*DATA_W +: DATA_W] = wdata0;
`endif
            end else begin
                w_rdata[i*DATA_W +: DATA_W] = r_mem[ra];
            end
        end
    end

    assign rdata    = w_rdata;
    assign clr_busy = r_clr_busy;

endmodule
